// File: rtl/arb_out_queue.sv
// arb_out_queue: output queue behind a 4-input arbiter. Stores {chosen, bits}
// pairs in arrival order and tracks occupancy overall and per chosen tag.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   io_enq_ready/valid/bits/chosen   enqueue handshake from the arbiter
//   io_deq_ready/valid/bits/chosen   dequeue handshake to the consumer
//   io_count                         current occupancy (0..ENTRIES)
//   io_src_count_0..3                occupancy per chosen tag value 0..3
module arb_out_queue #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned TW      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       io_enq_ready,
    input  logic                       io_enq_valid,
    input  logic [W-1:0]               io_enq_bits,
    input  logic [TW-1:0]              io_enq_chosen,
    input  logic                       io_deq_ready,
    output logic                       io_deq_valid,
    output logic [W-1:0]               io_deq_bits,
    output logic [TW-1:0]              io_deq_chosen,
    output logic [$clog2(ENTRIES):0]   io_count,
    output logic [$clog2(ENTRIES):0]   io_src_count_0,
    output logic [$clog2(ENTRIES):0]   io_src_count_1,
    output logic [$clog2(ENTRIES):0]   io_src_count_2,
    output logic [$clog2(ENTRIES):0]   io_src_count_3
);

    localparam int unsigned PW   = $clog2(ENTRIES);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned NSRC = 4;

    logic [W-1:0]  mem_bits   [ENTRIES];
    logic [TW-1:0] mem_chosen [ENTRIES];
    logic [PW-1:0] enq_ptr;
    logic [PW-1:0] deq_ptr;
    logic [PW-1:0] ptr_diff;
    logic          maybe_full;
    logic          ptr_match;
    logic          empty;
    logic          full;
    logic          enq_fire;
    logic          deq_fire;
    logic [CW-1:0] src_cnt [NSRC];
    logic [NSRC-1:0] src_inc;
    logic [NSRC-1:0] src_dec;

    // Queue status and handshake decode
    always_comb begin
        ptr_match    = (enq_ptr == deq_ptr);
        empty        = ptr_match && !maybe_full;
        full         = ptr_match && maybe_full;
        io_enq_ready = !full;
        io_deq_valid = !empty;
        enq_fire     = io_enq_valid && io_enq_ready;
        deq_fire     = io_deq_valid && io_deq_ready;
        io_deq_bits  = mem_bits[deq_ptr];
        io_deq_chosen = mem_chosen[deq_ptr];
        ptr_diff     = enq_ptr - deq_ptr;
        io_count     = full ? CW'(ENTRIES) : CW'(ptr_diff);
    end

    // Per-tag increment/decrement requests
    always_comb begin
        src_inc = '0;
        src_dec = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
            src_inc[k] = enq_fire && (int'(io_enq_chosen) == k);
            src_dec[k] = deq_fire && (int'(io_deq_chosen) == k);
        end
    end

    // Storage array; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_bits[enq_ptr]   <= io_enq_bits;
            mem_chosen[enq_ptr] <= io_enq_chosen;
        end
    end

    // Pointers and full/empty disambiguation flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (enq_fire) enq_ptr <= enq_ptr + PW'(1);
            if (deq_fire) deq_ptr <= deq_ptr + PW'(1);
            if (enq_fire != deq_fire) maybe_full <= enq_fire;
        end
    end

    // Per-tag occupancy counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(NSRC); k++) src_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < int'(NSRC); k++) begin
                if (src_inc[k] && !src_dec[k])      src_cnt[k] <= src_cnt[k] + CW'(1);
                else if (src_dec[k] && !src_inc[k]) src_cnt[k] <= src_cnt[k] - CW'(1);
            end
        end
    end

    assign io_src_count_0 = src_cnt[0];
    assign io_src_count_1 = src_cnt[1];
    assign io_src_count_2 = src_cnt[2];
    assign io_src_count_3 = src_cnt[3];

endmodule

// File: tb/tb_arb_out_queue.sv
// tb_arb_out_queue: scoreboard bench for arb_out_queue (ENTRIES=4, W=8, TW=2).
module tb_arb_out_queue;

    localparam int unsigned ENTRIES = 4;
    localparam int unsigned W       = 8;
    localparam int unsigned TW      = 2;
    localparam int unsigned CW      = 3;

    typedef struct packed {
        logic [TW-1:0] chosen;
        logic [W-1:0]  bits;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_enq_ready;
    logic          io_enq_valid;
    logic [W-1:0]  io_enq_bits;
    logic [TW-1:0] io_enq_chosen;
    logic          io_deq_ready;
    logic          io_deq_valid;
    logic [W-1:0]  io_deq_bits;
    logic [TW-1:0] io_deq_chosen;
    logic [CW-1:0] io_count;
    logic [CW-1:0] io_src_count_0;
    logic [CW-1:0] io_src_count_1;
    logic [CW-1:0] io_src_count_2;
    logic [CW-1:0] io_src_count_3;

    int     n_checks = 0;
    int     n_errors = 0;
    entry_t sb[$];

    arb_out_queue #(.ENTRIES(ENTRIES), .W(W), .TW(TW)) dut (
        .clk            (clk),
        .reset          (reset),
        .io_enq_ready   (io_enq_ready),
        .io_enq_valid   (io_enq_valid),
        .io_enq_bits    (io_enq_bits),
        .io_enq_chosen  (io_enq_chosen),
        .io_deq_ready   (io_deq_ready),
        .io_deq_valid   (io_deq_valid),
        .io_deq_bits    (io_deq_bits),
        .io_deq_chosen  (io_deq_chosen),
        .io_count       (io_count),
        .io_src_count_0 (io_src_count_0),
        .io_src_count_1 (io_src_count_1),
        .io_src_count_2 (io_src_count_2),
        .io_src_count_3 (io_src_count_3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_src(input int k);
        int n = 0;
        foreach (sb[i]) if (int'(sb[i].chosen) == k) n++;
        return n;
    endfunction

    // Compare all status outputs against the reference queue contents
    task automatic check_status(input string tag);
        check({tag, ".count"},  32'(io_count),       32'(sb.size()));
        check({tag, ".enq_rdy"}, 32'(io_enq_ready),  32'(sb.size() != ENTRIES));
        check({tag, ".deq_vld"}, 32'(io_deq_valid),  32'(sb.size() != 0));
        check({tag, ".src0"},   32'(io_src_count_0), 32'(model_src(0)));
        check({tag, ".src1"},   32'(io_src_count_1), 32'(model_src(1)));
        check({tag, ".src2"},   32'(io_src_count_2), 32'(model_src(2)));
        check({tag, ".src3"},   32'(io_src_count_3), 32'(model_src(3)));
    endtask

    // One clock: drive inputs, check at negedge, update the model, cross the edge
    task automatic step(input logic ev, input logic [TW-1:0] ec, input logic [W-1:0] eb,
                        input logic dr, input string tag);
        entry_t e;
        logic   enq_ok;
        logic   deq_ok;
        io_enq_valid  = ev;
        io_enq_chosen = ec;
        io_enq_bits   = eb;
        io_deq_ready  = dr;
        @(negedge clk);
        check_status(tag);
        enq_ok = ev && (sb.size() < ENTRIES);
        deq_ok = dr && (sb.size() > 0);
        if (deq_ok) begin
            e = sb.pop_front();
            check({tag, ".deq_chosen"}, 32'(io_deq_chosen), 32'(e.chosen));
            check({tag, ".deq_bits"},   32'(io_deq_bits),   32'(e.bits));
        end
        if (enq_ok) begin
            e.chosen = ec;
            e.bits   = eb;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, '0, '0, 1'b0, tag);
    endtask

    initial begin
        reset         = 1'b1;
        io_enq_valid  = 1'b0;
        io_enq_bits   = '0;
        io_enq_chosen = '0;
        io_deq_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.count",   32'(io_count),     32'd0);
        check("rst.enq_rdy", 32'(io_enq_ready), 32'd1);
        check("rst.deq_vld", 32'(io_deq_valid), 32'd0);
        reset = 1'b0;
        idle("post_rst");

        // Fill with tags 0..3, then a fifth valid that must be ignored
        for (int i = 0; i < 4; i++) step(1'b1, TW'(i), W'(8'h10 + i), 1'b0, "fill");
        step(1'b1, 2'd0, 8'hFF, 1'b0, "fill5");
        check("full.count",   32'(io_count),     32'd4);
        check("full.enq_rdy", 32'(io_enq_ready), 32'd0);
        check("full.src3",    32'(io_src_count_3), 32'd1);

        // Drain in order
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, "drain");
        check("drain.deq_vld", 32'(io_deq_valid), 32'd0);
        check("drain.count",   32'(io_count),     32'd0);

        // Two held, then concurrent enqueue+dequeue for 10 cycles
        step(1'b1, 2'd1, 8'h20, 1'b0, "conc_pre");
        step(1'b1, 2'd2, 8'h21, 1'b0, "conc_pre");
        for (int i = 0; i < 10; i++) step(1'b1, TW'(i), W'(8'h30 + i), 1'b1, "conc");
        check("conc.count", 32'(io_count), 32'd2);

        // Full with simultaneous valid/ready: only the dequeue fires
        step(1'b1, 2'd3, 8'h40, 1'b0, "fwd_fill");
        step(1'b1, 2'd0, 8'h41, 1'b0, "fwd_fill");
        step(1'b1, 2'd1, 8'h42, 1'b1, "fwd_both");
        check("fwd.count3", 32'(io_count), 32'd3);
        step(1'b1, 2'd1, 8'h42, 1'b0, "fwd_enq");
        check("fwd.count4", 32'(io_count), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, "fwd_drain");

        // Per-source counting: tags 2,2,1 then one dequeue
        step(1'b1, 2'd2, 8'h50, 1'b0, "src");
        step(1'b1, 2'd2, 8'h51, 1'b0, "src");
        step(1'b1, 2'd1, 8'h52, 1'b0, "src");
        step(1'b0, '0, '0, 1'b1, "src_deq");
        check("src.src2",  32'(io_src_count_2), 32'd1);
        check("src.src1",  32'(io_src_count_1), 32'd1);
        check("src.count", 32'(io_count),       32'd2);
        for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, "src_drain");

        // Asynchronous reset between edges with three entries held
        for (int i = 0; i < 3; i++) step(1'b1, TW'(i), W'(8'h60 + i), 1'b0, "ar_fill");
        check("ar.pre_count", 32'(io_count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("ar.count",   32'(io_count),       32'd0);
        check("ar.deq_vld", 32'(io_deq_valid),   32'd0);
        check("ar.enq_rdy", 32'(io_enq_ready),   32'd1);
        check("ar.src0",    32'(io_src_count_0), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle("ar_post");

        // Random traffic against the reference queue
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), TW'($urandom_range(0, 3)), W'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), "rand");
        while (sb.size() > 0) step(1'b0, '0, '0, 1'b1, "rand_drain");
        idle("end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/arb_out_queue.md
ARB_OUT_QUEUE -- requirements
Module: arb_out_queue

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 4, meaning queue depth (power of two, 2..16).
REQ-002 The block SHALL have parameter W, default 8, meaning payload width, matching the 4-input arbiter output bits.
REQ-003 The block SHALL have parameter TW, default 2, meaning chosen-tag width, matching the arbiter chosen index.
REQ-004 Port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port io_enq_ready  output  1  queue can accept an entry.
REQ-007 Port io_enq_valid  input  1  upstream arbiter output valid.
REQ-008 Port io_enq_bits  input  W  upstream arbiter output payload.
REQ-009 Port io_enq_chosen  input  TW  upstream arbiter chosen index, stored with the payload.
REQ-010 Port io_deq_ready  input  1  consumer accepts the head entry.
REQ-011 Port io_deq_valid  output  1  head entry present.
REQ-012 Port io_deq_bits  output  W  head payload.
REQ-013 Port io_deq_chosen  output  TW  head tag.
REQ-014 Port io_count  output  log2(ENTRIES)+1  current occupancy.
REQ-015 Ports io_src_count_0..io_src_count_3  output  log2(ENTRIES)+1 each  occupancy per tag value 0..3.

Function
REQ-016 Enqueue fire SHALL be io_enq_valid & io_enq_ready; dequeue fire SHALL be io_deq_valid & io_deq_ready.
REQ-017 Storage SHALL be an ENTRIES-deep array of {chosen, bits}, with enq_ptr and deq_ptr wrapping modulo ENTRIES, plus a maybe_full flag.
REQ-018 empty = (enq_ptr == deq_ptr) & !maybe_full; full = (enq_ptr == deq_ptr) & maybe_full.
REQ-019 io_enq_ready SHALL be !full (combinational, no dependence on io_deq_ready; no pipe bypass).
REQ-020 io_deq_valid SHALL be !empty; io_deq_bits/io_deq_chosen SHALL be combinational reads of the entry at deq_ptr (no flow-through: an entry enqueued at edge N is first visible after edge N).
REQ-021 On enqueue fire, the entry SHALL be written at enq_ptr and enq_ptr incremented; on dequeue fire, deq_ptr SHALL be incremented.
REQ-022 maybe_full SHALL be set on enqueue-fire without dequeue-fire, cleared on dequeue-fire without enqueue-fire, and held otherwise.
REQ-023 Simultaneous enqueue and dequeue fire (only possible when neither empty nor full) SHALL leave io_count and maybe_full unchanged.
REQ-024 io_count SHALL equal (enq_ptr - deq_ptr) mod ENTRIES, or ENTRIES when full.
REQ-025 io_src_count_k SHALL increment on enqueue fire with io_enq_chosen==k, decrement on dequeue fire with head tag==k, and hold if both or neither occur for k; sum of src counts SHALL always equal io_count.
REQ-026 io_enq_valid while full SHALL be ignored (no write, no pointer change); io_deq_ready while empty SHALL be ignored.
REQ-027 Latency SHALL be exactly one cycle from enqueue fire to io_deq_valid when previously empty.

Reset
REQ-028 Assertion of reset SHALL immediately (asynchronously) clear enq_ptr, deq_ptr, maybe_full and all source counts, mid-operation included; in-flight entries are discarded.
REQ-029 During and after reset: io_enq_ready=1, io_deq_valid=0, io_count=0, io_src_count_*=0; array contents are not reset and io_deq_bits/io_deq_chosen are don't-care while io_deq_valid=0.

Verification
REQ-030 Fill: deq_ready=0, enqueue 4 entries {chosen=0..3, bits=0x10..0x13} -> io_count=4, io_enq_ready=0, each src_count=1; 5th valid ignored.
REQ-031 Drain order: then deq_ready=1 for 4 cycles -> deq outputs (0,0x10),(1,0x11),(2,0x12),(3,0x13) in order, then io_deq_valid=0, io_count=0.
REQ-032 Concurrent: with 2 entries held, enq and deq fire every cycle for 10 cycles -> io_count stays 2, pointers wrap, data order preserved.
REQ-033 Full with deq: full queue, enq_valid=1 and deq_ready=1 -> that cycle only dequeue occurs, count 4->3; next cycle enqueue accepted.
REQ-034 Per-source: enqueue tags 2,2,1 then dequeue one -> src_count_2=1, src_count_1=1, io_count=2.
REQ-035 Async reset: assert reset between clock edges with 3 entries held -> io_count=0, io_deq_valid=0, io_enq_ready=1 before the next edge.
